// File: rtl/hazard_pkg.sv
// Shared types and constants for the semiMIPS hazard controller.
// State encoding, default mult/div latencies, and the opcode/funct values
// used by the decoder that produces the md/hilo qualifiers.
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } hz_state_e;

  localparam int DEF_MULT_LATENCY = 4;
  localparam int DEF_DIV_LATENCY  = 32;
  localparam int DEF_CNT_W        = 6;

  // All mult/div/mfhi/mflo live under the SPECIAL opcode, distinguished by funct.
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;

  // True for mult/multu/div/divu.
  function automatic logic is_md_op(input logic [5:0] opcode, input logic [5:0] funct);
    return (opcode == OP_SPECIAL) &&
           ((funct == FN_MULT) || (funct == FN_MULTU) ||
            (funct == FN_DIV)  || (funct == FN_DIVU));
  endfunction

  // True for mfhi/mflo.
  function automatic logic is_hilo_rd(input logic [5:0] opcode, input logic [5:0] funct);
    return (opcode == OP_SPECIAL) && ((funct == FN_MFHI) || (funct == FN_MFLO));
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_latency_counter.sv
// Down-counter tracking remaining mult/div latency: load, decrement, zero flag.
// Load has priority over decrement; the count stops at zero rather than wrapping.
// Synchronous active-low reset clears the count.
module md_latency_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: a fresh load wins, otherwise step down until zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard controller: load-use stall, branch flush, mult/div sequencing and HI/LO RAW stall.
// Outputs are combinational from state, mdcnt and current inputs (zero-cycle decision).
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush counters and their ports.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_LATENCY = DEF_MULT_LATENCY,
  parameter int DIV_LATENCY  = DEF_DIV_LATENCY,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        idexmemrd,
  input  logic [4:0]  idexregmuxout,
  input  logic        idexmd,
  input  logic        idexmdop,
  input  logic [4:0]  ifidrs,
  input  logic [4:0]  ifidrt,
  input  logic        ifidusesrt,
  input  logic        ifidmd,
  input  logic        ifidhilo,
  input  logic        exbrtaken,
  output logic        pcwr,
  output logic        ifidwr,
  output logic        ifidflush,
  output logic        idexbubble,
  output logic        md_start,
  output logic        md_busy,
`ifdef HAZARD_PERF_CNT_EN
  output logic        md_done,
  output logic [31:0] perf_lu_stalls,
  output logic [31:0] perf_md_stalls,
  output logic [31:0] perf_flushes
`else
  output logic        md_done
`endif
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LATENCY - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LATENCY - 1);

  hz_state_e        state_q;
  hz_state_e        state_d;
  logic [CNT_W-1:0] mdcnt;
  logic             mdcnt_zero;
  logic             lu_hazard;
  logic             md_hazard;
  logic             in_wait;

  assign in_wait = (state_q == MD_WAIT);

  // A load's destination matches a source of the instruction behind it; $0 never conflicts.
  assign lu_hazard = idexmemrd && (idexregmuxout != 5'd0) &&
                     ((idexregmuxout == ifidrs) ||
                      (ifidusesrt && (idexregmuxout == ifidrt)));

  // HI/LO consumers and new mult/div ops wait until the last busy cycle.
  assign md_hazard = in_wait && !mdcnt_zero && (ifidmd || ifidhilo);

  md_latency_counter #(
    .CNT_W (CNT_W)
  ) u_mdcnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (md_start),
    .load_val_i (idexmdop ? DIV_LOAD : MULT_LOAD),
    .dec_i      (in_wait),
    .cnt_o      (mdcnt),
    .zero_o     (mdcnt_zero)
  );

  // Next state and pipeline controls; reset forces the pipe into a flushed, stalled shape.
  always_comb begin
    state_d    = state_q;
    pcwr       = 1'b1;
    ifidwr     = 1'b1;
    ifidflush  = 1'b0;
    idexbubble = 1'b0;
    md_start   = 1'b0;
    md_busy    = 1'b0;
    md_done    = 1'b0;

    if (!rst_n) begin
      pcwr       = 1'b0;
      ifidwr     = 1'b0;
      ifidflush  = 1'b1;
      idexbubble = 1'b1;
    end else begin
      // Branch resolution wins: whatever would have stalled is wrong-path.
      if (exbrtaken) begin
        ifidflush  = 1'b1;
        idexbubble = 1'b1;
      end else if (lu_hazard || md_hazard) begin
        pcwr       = 1'b0;
        ifidwr     = 1'b0;
        idexbubble = 1'b1;
      end

      unique case (state_q)
        RUN: begin
          // The mult/div is older than any branch in EX, so it issues regardless of flush.
          if (idexmd) begin
            md_start = 1'b1;
            state_d  = MD_WAIT;
          end
        end
        MD_WAIT: begin
          // A stray idexmd here is ignored; the in-flight op is never restarted.
          md_busy = 1'b1;
          if (mdcnt_zero) begin
            md_done = 1'b1;
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State register; reset abandons any in-flight operation without a done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lu_q;
  logic [31:0] perf_md_q;
  logic [31:0] perf_fl_q;

  // Saturating event counters; a flush cycle is not counted as a stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_lu_q <= '0;
      perf_md_q <= '0;
      perf_fl_q <= '0;
    end else begin
      if (lu_hazard && !exbrtaken && (perf_lu_q != '1)) perf_lu_q <= perf_lu_q + 32'd1;
      if (md_hazard && !exbrtaken && (perf_md_q != '1)) perf_md_q <= perf_md_q + 32'd1;
      if (exbrtaken && (perf_fl_q != '1))               perf_fl_q <= perf_fl_q + 32'd1;
    end
  end

  assign perf_lu_stalls = perf_lu_q;
  assign perf_md_stalls = perf_md_q;
  assign perf_flushes   = perf_fl_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector bench for hazard_stall_ctrl with hand-computed expected outputs.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
// Output vector order: {pcwr, ifidwr, ifidflush, idexbubble, md_start, md_busy, md_done}.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       idexmemrd;
  logic [4:0] idexregmuxout;
  logic       idexmd;
  logic       idexmdop;
  logic [4:0] ifidrs;
  logic [4:0] ifidrt;
  logic       ifidusesrt;
  logic       ifidmd;
  logic       ifidhilo;
  logic       exbrtaken;
  logic       pcwr, ifidwr, ifidflush, idexbubble, md_start, md_busy, md_done;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lu_stalls, perf_md_stalls, perf_flushes;
`endif

  int n_vec = 0;
  int n_err = 0;

  localparam logic [6:0] O_RST   = 7'b0011000;
  localparam logic [6:0] O_RUN   = 7'b1100000;
  localparam logic [6:0] O_STALL = 7'b0001000;
  localparam logic [6:0] O_FLUSH = 7'b1111000;
  localparam logic [6:0] O_START = 7'b1100100;
  localparam logic [6:0] O_BUSY  = 7'b1100010;
  localparam logic [6:0] O_MDSTL = 7'b0001010;
  localparam logic [6:0] O_DONE  = 7'b1100011;

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .idexmemrd     (idexmemrd),
    .idexregmuxout (idexregmuxout),
    .idexmd        (idexmd),
    .idexmdop      (idexmdop),
    .ifidrs        (ifidrs),
    .ifidrt        (ifidrt),
    .ifidusesrt    (ifidusesrt),
    .ifidmd        (ifidmd),
    .ifidhilo      (ifidhilo),
    .exbrtaken     (exbrtaken),
    .pcwr          (pcwr),
    .ifidwr        (ifidwr),
    .ifidflush     (ifidflush),
    .idexbubble    (idexbubble),
    .md_start      (md_start),
    .md_busy       (md_busy),
`ifdef HAZARD_PERF_CNT_EN
    .md_done       (md_done),
    .perf_lu_stalls(perf_lu_stalls),
    .perf_md_stalls(perf_md_stalls),
    .perf_flushes  (perf_flushes)
`else
    .md_done       (md_done)
`endif
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Settle, compare all seven controls, then advance one clock.
  task automatic vec(input string tag, input logic [6:0] exp);
    #1;
    check_vec(tag, {25'd0, pcwr, ifidwr, ifidflush, idexbubble, md_start, md_busy, md_done},
              {25'd0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; idexmemrd = 1'b0; idexregmuxout = 5'd0; idexmd = 1'b1; idexmdop = 1'b0;
    ifidrs = 5'd0; ifidrt = 5'd0; ifidusesrt = 1'b0; ifidmd = 1'b0; ifidhilo = 1'b0;
    exbrtaken = 1'b0;

    // Reset: controls forced even with a mult/div presented.
    vec("reset_a", O_RST);
    idexmd = 1'b0;
    vec("reset_b", O_RST);
    rst_n = 1'b1;
    vec("idle", O_RUN);

    // lw $3 ; add $4,$3,$5 -> one stall, then the load has moved on.
    idexmemrd = 1'b1; idexregmuxout = 5'd3; ifidrs = 5'd3; ifidrt = 5'd5; ifidusesrt = 1'b1;
    vec("lu_rs", O_STALL);
    idexmemrd = 1'b0;
    vec("lu_clear", O_RUN);
    // Match on rt only when rt is a source.
    idexmemrd = 1'b1; ifidrs = 5'd4; ifidrt = 5'd3; ifidusesrt = 1'b1;
    vec("lu_rt", O_STALL);
    ifidusesrt = 1'b0;
    vec("lu_rt_unused", O_RUN);
    // Destination $0 never stalls.
    idexregmuxout = 5'd0; ifidrs = 5'd0; ifidrt = 5'd0; ifidusesrt = 1'b1;
    vec("lu_r0", O_RUN);
    // Branch taken overrides load-use.
    idexregmuxout = 5'd3; ifidrs = 5'd3; exbrtaken = 1'b1;
    vec("lu_branch", O_FLUSH);
    exbrtaken = 1'b0; idexmemrd = 1'b0; ifidusesrt = 1'b0;

    // mult (latency 4) then mfhi in IF/ID; a branch mid-wait flushes but does not cancel.
    idexmd = 1'b1; idexmdop = 1'b0;
    vec("mult_start", O_START);
    idexmd = 1'b0; ifidhilo = 1'b1;
    vec("mult_stall_c3", O_MDSTL);
    exbrtaken = 1'b1;
    vec("mult_flush_c2", 7'b1111010);
    exbrtaken = 1'b0;
    vec("mult_stall_c1", O_MDSTL);
    vec("mult_done", O_DONE);
    vec("mult_run", O_RUN);
    ifidhilo = 1'b0;

    // div issued alongside a taken branch; later a mult waits in IF/ID until done.
    idexmd = 1'b1; idexmdop = 1'b1; exbrtaken = 1'b1;
    vec("div_start_br", 7'b1111100);
    idexmd = 1'b0; exbrtaken = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      ifidmd = (k >= 20);
      if (k == 32)      vec($sformatf("div_c%0d", k), O_DONE);
      else if (k >= 20) vec($sformatf("div_c%0d", k), O_MDSTL);
      else              vec($sformatf("div_c%0d", k), O_BUSY);
    end
    // Second mult now in ID/EX; holding idexmd in MD_WAIT must not restart it.
    ifidmd = 1'b0; idexmd = 1'b1; idexmdop = 1'b0;
    vec("mult2_start", O_START);
    vec("mult2_c1_idexmd", O_BUSY);
    idexmd = 1'b0;
    vec("mult2_c2", O_BUSY);
    vec("mult2_c3", O_BUSY);
    vec("mult2_done", O_DONE);
    vec("mult2_run", O_RUN);

    // Reset with div in flight at mdcnt=10: abandoned, no done pulse afterwards.
    idexmd = 1'b1; idexmdop = 1'b1;
    vec("div2_start", O_START);
    idexmd = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    vec("rst_inflight_a", O_RST);
    vec("rst_inflight_b", O_RST);
    rst_n = 1'b1;
`ifdef HAZARD_PERF_CNT_EN
    #1;
    check_vec("perf_lu_rst", perf_lu_stalls, 32'd0);
    check_vec("perf_md_rst", perf_md_stalls, 32'd0);
    check_vec("perf_fl_rst", perf_flushes, 32'd0);
`endif
    for (int k = 0; k < 12; k++) begin
      vec($sformatf("post_rst_%0d", k), O_RUN);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
